// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits are served combinationally; misses stall the CPU while whole lines move over a req/ack port.
module dcache_controller #(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 32 - 5 - IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    state_e               state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [TAG_W-1:0]     miss_tag_q;
    logic [IDX_W-1:0]     miss_idx_q;
    logic                 mem_req_q;
    logic                 mem_write_q;
    logic [31:0]          mem_addr_q;
    logic [LINE_W-1:0]    mem_data_q;

    logic [TAG_W-1:0]     req_tag_s;
    logic [IDX_W-1:0]     req_idx_s;
    logic [2:0]           word_s;
    logic [7:0]           bit_off_s;
    logic                 hit_s;
    logic                 miss_s;
    logic                 victim_dirty_s;
    logic                 unused_s;

    assign req_tag_s      = cpu_addr_i[31:5+IDX_W];
    assign req_idx_s      = cpu_addr_i[4+IDX_W:5];
    assign word_s         = cpu_addr_i[4:2];
    assign bit_off_s      = {word_s, 5'b00000};
    assign unused_s       = ^cpu_addr_i[1:0];
    assign hit_s          = (state_q == ST_IDLE) & cpu_req_i & valid_q[req_idx_s]
                            & (tag_q[req_idx_s] == req_tag_s);
    assign miss_s         = (state_q == ST_IDLE) & cpu_req_i & ~hit_s;
    assign victim_dirty_s = valid_q[req_idx_s] & dirty_q[req_idx_s];

    assign mem_req_o   = mem_req_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;

    // CPU-facing hit data and stall; forced quiet while reset is asserted.
    always_comb begin
        cpu_stall_o = 1'b0;
        cpu_data_o  = 32'h0000_0000;
        if (!rst_i) begin
            cpu_stall_o = 1'b0;
            cpu_data_o  = 32'h0000_0000;
        end else begin
            cpu_stall_o = (state_q != ST_IDLE) | miss_s;
            if (hit_s && !cpu_write_i) begin
                cpu_data_o = data_q[req_idx_s][bit_off_s +: 32];
            end else begin
                cpu_data_o = 32'h0000_0000;
            end
        end
    end

    // Miss-handling FSM; memory-side outputs are registered and held until ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_s && cpu_write_i) begin
                        dirty_q[req_idx_s] <= 1'b1;
                    end else if (miss_s) begin
                        miss_tag_q <= req_tag_s;
                        miss_idx_q <= req_idx_s;
                        mem_req_q  <= 1'b1;
                        if (victim_dirty_s) begin
                            state_q     <= ST_WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[req_idx_s], req_idx_s, 5'b00000};
                            mem_data_q  <= data_q[req_idx_s];
                        end else begin
                            state_q     <= ST_ALLOCATE;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= {req_tag_s, req_idx_s, 5'b00000};
                            mem_data_q  <= '0;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        dirty_q[miss_idx_q] <= 1'b0;
                        state_q             <= ST_ALLOCATE;
                        mem_write_q         <= 1'b0;
                        mem_addr_q          <= {miss_tag_q, miss_idx_q, 5'b00000};
                        mem_data_q          <= '0;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        state_q             <= ST_IDLE;
                        mem_req_q           <= 1'b0;
                        mem_write_q         <= 1'b0;
                        mem_addr_q          <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    mem_req_q   <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_addr_q  <= 32'h0000_0000;
                    mem_data_q  <= '0;
                end
            endcase
        end
    end

    // Tag and data arrays; unreset since every read is qualified by valid_q.
    always_ff @(posedge clk_i) begin
        if ((state_q == ST_ALLOCATE) && mem_ack_i) begin
            data_q[miss_idx_q] <= mem_data_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end else if (hit_s && cpu_write_i) begin
            data_q[req_idx_s][bit_off_s +: 32] <= cpu_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a flat-memory reference model predicts load data,
// line transfers and stall lengths; a monitor checks them as the DUT presents them.
module tb_dcache_controller;
    localparam int LINE_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cpu_req_i;
    logic              cpu_write_i;
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
    logic              mem_req_o;
    logic              mem_write_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i = '0;
    logic              mem_ack_i = 1'b0;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct { bit is_load; logic [31:0] data; int stall; } acc_t;
    typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } mtx_t;
    acc_t exp_acc[$];
    mtx_t exp_mem[$];

    // Reference: architectural word memory, backing word memory, and per-index residency.
    logic [31:0] arch [logic [31:0]];
    logic [31:0] back [logic [31:0]];
    bit          mvalid [16];
    bit          mdirty [16];
    logic [22:0] mtag   [16];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rd_arch(input logic [31:0] a);
        if (arch.exists(a)) return arch[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rd_back(input logic [31:0] a);
        if (back.exists(a)) return back[a];
        return init_word(a);
    endfunction

    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input int lat);
        int   idx;
        bit   hit;
        bit   wb;
        mtx_t m;
        acc_t e;
        idx = int'(addr[8:5]);
        wb  = 1'b0;
        hit = mvalid[idx] && (mtag[idx] == addr[31:9]);
        if (!hit) begin
            if (mvalid[idx] && mdirty[idx]) begin
                wb     = 1'b1;
                m.wr   = 1'b1;
                m.addr = {mtag[idx], addr[8:5], 5'b00000};
                for (int w = 0; w < 8; w++) begin
                    m.data[w*32 +: 32] = rd_arch(m.addr + 32'(w * 4));
                    back[m.addr + 32'(w * 4)] = m.data[w*32 +: 32];
                end
                exp_mem.push_back(m);
            end
            m.wr   = 1'b0;
            m.addr = {addr[31:5], 5'b00000};
            m.data = '0;
            exp_mem.push_back(m);
            mvalid[idx] = 1'b1;
            mtag[idx]   = addr[31:9];
            mdirty[idx] = 1'b0;
        end
        e.is_load = !wr;
        e.data    = rd_arch(addr);
        e.stall   = hit ? 0 : (wb ? 2 * lat + 1 : lat + 1);
        if (wr) begin
            arch[addr]  = data;
            mdirty[idx] = 1'b1;
        end
        exp_acc.push_back(e);
    endtask

    task automatic model_reset();
        logic [31:0] base;
        logic [3:0]  ii;
        for (int i = 0; i < 16; i++) begin
            if (mvalid[i] && mdirty[i]) begin
                ii   = i[3:0];
                base = {mtag[i], ii, 5'b00000};
                for (int w = 0; w < 8; w++) arch[base + 32'(w * 4)] = rd_back(base + 32'(w * 4));
            end
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
    endtask

    // Memory responder with its own line store.
    logic [255:0] resp_mem [logic [31:0]];
    int ack_lat  = 3;
    int resp_cnt = 0;
    bit inj_ack  = 1'b0;

    function automatic logic [255:0] resp_line(input logic [31:0] a);
        logic [255:0] l;
        if (resp_mem.exists(a)) return resp_mem[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(a + 32'(w * 4));
        return l;
    endfunction

    always @(posedge clk_i) begin
        #1;
        if (!rst_i) begin
            mem_ack_i = 1'b0;
            resp_cnt  = 0;
        end else if (inj_ack) begin
            mem_ack_i = 1'b1;
            inj_ack   = 1'b0;
        end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            resp_cnt  = mem_req_o ? 1 : 0;
        end else if (mem_req_o) begin
            resp_cnt++;
            if (resp_cnt >= ack_lat) begin
                mem_ack_i = 1'b1;
                if (mem_write_o) resp_mem[mem_addr_o] = mem_data_o;
                else mem_data_i = resp_line(mem_addr_o);
            end
        end else begin
            resp_cnt = 0;
        end
    end

    // Monitor: pops expectations when a transfer is acked or a CPU access completes.
    bit          mon_en    = 1'b1;
    int          stall_cnt = 0;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic        prev_wr   = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    mtx_t        mon_m;
    acc_t        mon_e;

    always @(negedge clk_i) begin
        if (mon_en && rst_i) begin
            if (mem_req_o && prev_req && !prev_ack) begin
                chk("mem_addr stable", mem_addr_o, prev_addr);
                chk("mem_write stable", mem_write_o, prev_wr);
            end
            if (mem_req_o && mem_ack_i) begin
                n_checks++;
                if (exp_mem.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected mem txn: got addr %h write %b expected none",
                             mem_addr_o, mem_write_o);
                end else begin
                    mon_m = exp_mem.pop_front();
                    chk("mem_write", mem_write_o, mon_m.wr);
                    chk("mem_addr", mem_addr_o, mon_m.addr);
                    if (mon_m.wr) chk("writeback data", mem_data_o, mon_m.data);
                end
            end
            if (cpu_req_i) begin
                if (cpu_stall_o) begin
                    stall_cnt++;
                end else begin
                    n_checks++;
                    if (exp_acc.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected access completion: got addr %h expected none",
                                 cpu_addr_i);
                    end else begin
                        mon_e = exp_acc.pop_front();
                        chk("stall cycles", stall_cnt, mon_e.stall);
                        if (mon_e.is_load) chk("load data", cpu_data_o, mon_e.data);
                    end
                    stall_cnt = 0;
                end
            end
        end
        prev_req  = mem_req_o;
        prev_ack  = mem_ack_i;
        prev_addr = mem_addr_o;
        prev_wr   = mem_write_o;
    end

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input int lat);
        int c;
        ack_lat = lat;
        model_access(wr, addr, data, lat);
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = data;
        c = 0;
        do begin
            @(negedge clk_i);
            c++;
        end while (cpu_stall_o && c < 200);
        chk("access timeout", cpu_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        bit          wr;
        rst_i       = 1'b0;
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_0040;
        cpu_data_i  = 32'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset cpu_stall", cpu_stall_o, 1'b0);
        chk("reset cpu_data", cpu_data_o, 32'h0);
        chk("reset mem_req", mem_req_o, 1'b0);
        chk("reset mem_write", mem_write_o, 1'b0);
        chk("reset mem_addr", mem_addr_o, 32'h0);
        chk("reset mem_data", mem_data_o, 256'h0);
        cpu_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        access(1'b0, 32'h0000_0040, 32'h0, 3);
        access(1'b0, 32'h0000_0044, 32'h0, 2);
        access(1'b1, 32'h0000_0048, 32'h1234_5678, 2);
        access(1'b0, 32'h0000_0248, 32'h0, 3);
        access(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 3);
        access(1'b0, 32'h0000_0100, 32'h0, 2);

        mon_en      = 1'b0;
        ack_lat     = 20;
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_0060;
        repeat (3) @(posedge clk_i);
        #1;
        chk("abort pre mem_req", mem_req_o, 1'b1);
        chk("abort pre mem_addr", mem_addr_o, 32'h0000_0060);
        chk("abort pre stall", cpu_stall_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("abort mem_req", mem_req_o, 1'b0);
        chk("abort stall", cpu_stall_o, 1'b0);
        chk("abort mem_addr", mem_addr_o, 32'h0);
        cpu_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        model_reset();
        mon_en = 1'b1;
        @(posedge clk_i);
        #1;
        access(1'b0, 32'h0000_0040, 32'h0, 3);

        @(negedge clk_i);
        inj_ack = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("idle ack mem_req", mem_req_o, 1'b0);
            chk("idle ack stall", cpu_stall_o, 1'b0);
        end
        @(posedge clk_i);
        #1;
        access(1'b0, 32'h0000_005C, 32'h0, 2);

        for (int i = 0; i < 150; i++) begin
            a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 5)) << 5)
                 | (32'($urandom_range(0, 7)) << 2);
            wr = ($urandom_range(0, 1) != 0);
            access(wr, a, $urandom, int'($urandom_range(2, 5)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i);
                #1;
            end
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("access queue drained", exp_acc.size(), 0);
        chk("mem queue drained", exp_mem.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits between the CPU's MEM stage (EX/MEM address, store data, MemRead/MemWrite) and a wide off-chip data memory.
- Stalls the whole pipeline on a miss, serves hits in the same cycle, and moves whole lines to and from memory over a req/ack handshake.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2); index width IDX_W = log2(NUM_LINES) = 4.
- LINE_W, 256, line width in bits (32 bytes, 8 words).
- TAG_W, 23, tag width = 32 - 5 - IDX_W.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- cpu_req_i  in  1  access valid (MemRead | MemWrite)
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address, word aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  freeze pipeline
- mem_req_o  out  1  memory request, held until ack
- mem_write_o  out  1  1 = line write-back, 0 = line fetch
- mem_addr_o  out  32  line-aligned address (low 5 bits zero)
- mem_data_o  out  LINE_W  write-back line
- mem_data_i  in  LINE_W  fetched line
- mem_ack_i  in  1  single-cycle completion pulse

Behaviour:
- Address split: offset [4:0], word select [4:2], index [4+IDX_W:5], tag [31:5+IDX_W].
- Per-line storage: valid, dirty, tag, LINE_W data.
- Hit = cpu_req_i & valid[idx] & (tag[idx] == addr tag), evaluated in IDLE only.
- Reset (rst_i = 0, async): state IDLE; all valid and dirty bits cleared (data/tag arrays need no reset).
  - Outputs during/after reset: cpu_stall_o = 0, mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, cpu_data_o = 0.
- FSM states:
  - IDLE:
    - Read hit: cpu_data_o = selected word combinationally, stall = 0.
    - Write hit: word updated at the clock edge, dirty set, stall = 0.
    - Miss: cpu_stall_o = 1 combinationally in the same cycle. Next state WRITEBACK if victim valid & dirty, else ALLOCATE.
    - No request: cpu_data_o = 0, stall = 0.
  - WRITEBACK:
    - mem_req_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line, stall = 1.
    - On mem_ack_i: clear dirty, go to ALLOCATE.
  - ALLOCATE:
    - mem_req_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}, stall = 1.
    - On mem_ack_i: line <= mem_data_i, tag <= req tag, valid = 1, dirty = 0, go to IDLE.
- Returning to IDLE, the still-held request re-evaluates as a hit:
  - Loads return data and stall drops in that cycle.
  - Stores merge and set dirty on that edge (write-allocate).
- Latency:
  - Hit: 0 extra cycles.
  - Clean miss: ack latency + 1 cycle.
  - Dirty miss: two ack latencies + 1 cycle.
- Handshake:
  - mem_req_o and all mem_* outputs stay stable from first assertion until the ack cycle.
  - mem_req_o drops the cycle after the ack.
  - mem_ack_i is ignored in IDLE.
  - Memory may ack no earlier than 1 cycle after req rises.
- CPU obligation: cpu_req_i/addr/data held stable while cpu_stall_o = 1. If cpu_req_i drops mid-miss, the refill still completes and the line is installed.
- Reset mid-miss: FSM aborts to IDLE, memory request drops immediately, all lines invalid. Dirty data is lost by design.
- Wrap-around / aliasing: addresses differing only in tag map to the same index and evict each other.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning a line whose word0 = 0xDEAD_BEEF, ack after 3 cycles. Required: stall for 4 cycles, one fetch at mem_addr_o 0x40 with mem_write_o = 0, cpu_data_o = 0xDEADBEEF, no write-back.
- Repeat load 0x44 right after. Required: hit, stall = 0, returns word1 of the same line, no mem_req_o.
- Store 0x1234_5678 to 0x48 (hit), then load 0x0000_0248 (same index 2, different tag). Required: WRITEBACK to 0x40 with mem_data_o[95:64] = 0x12345678, then fetch at 0x240.
- Store miss to 0x0000_0100 with value 0xA5A5_A5A5. Required: fetch at 0x100, line installed, word0 overwritten with 0xA5A5A5A5, dirty set; a later load of 0x100 hits with 0xA5A5A5A5.
- Assert rst_i = 0 while in ALLOCATE. Required: mem_req_o = 0 and cpu_stall_o = 0 immediately; after release, load of 0x40 misses again.
- Assert mem_ack_i in IDLE with no request. Required: no state change, mem_req_o stays 0.
